// File: rtl/keypad_scan4.sv
// 4x4 matrix keypad scanner: row strobe, column sync, frame debounce, one-deep key event.
// Define KEYPAD_DIGITS_EN to add the oDIGITS history of the last four key codes.
module keypad_scan4 #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  oROW,
    input  logic [3:0]  iCOL,
    output logic [15:0] oKEYS,
    output logic [3:0]  oKEY,
    output logic        oVALID,
    output logic        oOVR,
    input  logic        iACK
`ifdef KEYPAD_DIGITS_EN
    ,
    output logic [15:0] oDIGITS
`endif
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STB_MAX  = SW'(DEBOUNCE);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [CW-1:0] cnt;
    logic [1:0]    r;
    logic [15:0]   raw;
    logic [15:0]   prev;
    logic [15:0]   newp;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_next;
    logic          frame_end;
    logic          sample;
    logic [3:0]    code;
    logic          ev_load;

    // Columns idle high (pulled up), so the synchronizer resets to all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            // NOTE: non-blocking so col_sync takes the previous col_meta, giving two real flops.
            col_meta <= iCOL;
            col_sync <= col_meta;
        end
    end

    assign sample = (cnt == CNT_LAST);
    assign oROW   = ~(4'b0001 << r);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            r         <= '0;
            raw       <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= sample && (r == 2'd3);
            if (sample) begin
                cnt                  <= '0;
                r                    <= r + 2'd1;
                raw[{r, 2'b00} +: 4] <= ~col_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves stable_next unassigned (no latch).
        stable_next = '0;
        if (raw == prev)
            stable_next = (stable == STB_MAX) ? stable : stable + 1'b1;
    end

    // newp is a one-cycle pulse: held keys never re-trigger the event stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            prev   <= '0;
            oKEYS  <= '0;
            newp   <= '0;
        end else begin
            newp <= '0;
            if (frame_end) begin
                stable <= stable_next;
                prev   <= raw;
                if (stable_next == STB_MAX) begin
                    oKEYS <= raw;
                    newp  <= raw & ~oKEYS;
                end
            end
        end
    end

    // Lowest-numbered new key wins; other simultaneous presses are dropped.
    always_comb begin
        code = '0;
        for (int i = 15; i >= 0; i--)
            if (newp[i]) code = 4'(i);
    end

    assign ev_load = (newp != '0) && (!oVALID || iACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oKEY   <= '0;
            oVALID <= 1'b0;
            oOVR   <= 1'b0;
        end else if (newp != '0) begin
            if (ev_load) begin
                oKEY   <= code;
                oVALID <= 1'b1;
                oOVR   <= 1'b0;
            end else begin
                oOVR <= 1'b1;
            end
        end else if (iACK && oVALID) begin
            oVALID <= 1'b0;
            oOVR   <= 1'b0;
        end
    end

`ifdef KEYPAD_DIGITS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            oDIGITS <= '0;
        else if (ev_load)
            oDIGITS <= {oDIGITS[11:0], code};
    end
`endif

endmodule

// File: tb/tb_keypad_scan4.sv
// Scoreboard bench for keypad_scan4: expected key events are queued at stimulus time
// and popped by a monitor whenever the DUT loads a new event.
module tb_keypad_scan4;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int BOUND    = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  oROW;
    logic [3:0]  iCOL;
    logic [15:0] oKEYS;
    logic [3:0]  oKEY;
    logic        oVALID;
    logic        oOVR;
    logic        iACK = 1'b0;
`ifdef KEYPAD_DIGITS_EN
    logic [15:0] oDIGITS;
`endif

    logic [15:0] key_down = '0;
    logic [3:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    keypad_scan4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .oROW    (oROW),
        .iCOL    (iCOL),
        .oKEYS   (oKEYS),
        .oKEY    (oKEY),
        .oVALID  (oVALID),
        .oOVR    (oOVR),
        .iACK    (iACK)
`ifdef KEYPAD_DIGITS_EN
        ,
        .oDIGITS (oDIGITS)
`endif
    );

    // Keypad model: a pressed key pulls its column low only while its row is driven.
    always_comb begin
        iCOL = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!oROW[rr] && key_down[rr*4+cc]) iCOL[cc] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: an event is a rise of oVALID or a new code loaded while oVALID stays high.
    logic       prev_valid = 1'b0;
    logic [3:0] prev_key = '0;
    logic [3:0] mon_exp;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_key   = '0;
        end else begin
            if (oVALID === 1'b1 && (!prev_valid || oKEY !== prev_key)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got key %0d, expected no event", oKEY);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("event_key", {12'h0, oKEY}, {12'h0, mon_exp});
                end
            end
            prev_valid = oVALID;
            prev_key   = oKEY;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk) iACK = 1'b1;
        @(negedge clk) iACK = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (oVALID !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'h0, oVALID}, 16'h0001);
    endtask

    task automatic wait_ovr(input string name);
        int n = 0;
        while (oOVR !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'h0, oOVR}, 16'h0001);
    endtask

    task automatic wait_keys(input string name, input logic [15:0] exp);
        int n = 0;
        while (oKEYS !== exp && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check(name, oKEYS, exp);
    endtask

    task automatic press_ack(input int k);
        int n;
        exp_q.push_back(4'(k));
        key_down[k] = 1'b1;
        wait_valid("digit_press_valid", n);
        ack();
        key_down[k] = 1'b0;
        wait_keys("digit_release", 16'h0000);
    endtask

    initial begin
        int n;
        int found;

        // Reset state
        tick(3);
        check("rst_row",   {12'h0, oROW}, 16'h000E);
        check("rst_keys",  oKEYS, 16'h0000);
        check("rst_key",   {12'h0, oKEY}, 16'h0000);
        check("rst_valid", {15'h0, oVALID}, 16'h0000);
        check("rst_ovr",   {15'h0, oOVR}, 16'h0000);
`ifdef KEYPAD_DIGITS_EN
        check("rst_digits", oDIGITS, 16'h0000);
`endif
        reset_n = 1'b1;
        tick(1);

        // Single press of key 6, ack, hold without repeat, release without event
        exp_q.push_back(4'd6);
        key_down[6] = 1'b1;
        wait_valid("press6_valid", n);
        vectors++;
        if (n > 68) begin
            miscompares++;
            $display("FAIL press6_latency: got %0d cycles, expected at most 68", n);
        end
        check("press6_keys", oKEYS, 16'h0040);
        ack();
        check("press6_ack_valid", {15'h0, oVALID}, 16'h0000);
        tick(5 * FRAME);
        check("press6_no_repeat", {15'h0, oVALID}, 16'h0000);
        key_down[6] = 1'b0;
        wait_keys("release6_keys", 16'h0000);
        tick(3 * FRAME);
        check("release6_no_event", {15'h0, oVALID}, 16'h0000);

        // Bounce on key 9 for about three frames, then hold
        exp_q.push_back(4'd9);
        for (int i = 0; i < 10; i++) begin
            key_down[9] = ~key_down[9];
            tick(5);
        end
        check("bounce_no_event", {15'h0, oVALID}, 16'h0000);
        check("bounce_keys", oKEYS, 16'h0000);
        key_down[9] = 1'b1;
        wait_valid("bounce9_valid", n);
        check("bounce9_keys", oKEYS, 16'h0200);
        ack();
        key_down[9] = 1'b0;
        wait_keys("release9_keys", 16'h0000);
        tick(2 * FRAME);
        check("release9_no_event", {15'h0, oVALID}, 16'h0000);

        // Overrun: key 1 left unacknowledged, then key 12 is lost
        exp_q.push_back(4'd1);
        key_down[1] = 1'b1;
        wait_valid("ovr_key1_valid", n);
        key_down[1] = 1'b0;
        wait_keys("ovr_release1", 16'h0000);
        key_down[12] = 1'b1;
        wait_ovr("ovr_set");
        check("ovr_key_kept", {12'h0, oKEY}, 16'h0001);
        check("ovr_valid",    {15'h0, oVALID}, 16'h0001);
        check("ovr_keys",     oKEYS, 16'h1000);
        ack();
        check("ovr_ack_valid", {15'h0, oVALID}, 16'h0000);
        check("ovr_ack_ovr",   {15'h0, oOVR}, 16'h0000);
        key_down[12] = 1'b0;
        wait_keys("ovr_release12", 16'h0000);

        // Simultaneous keys 3 and 12, then asynchronous reset mid-scan
        exp_q.push_back(4'd3);
        key_down[3]  = 1'b1;
        key_down[12] = 1'b1;
        wait_valid("simul_valid", n);
        check("simul_key",  {12'h0, oKEY}, 16'h0003);
        check("simul_keys", oKEYS, 16'h1008);
        tick(2 * FRAME);
        check("simul_single_event", {15'h0, oVALID}, 16'h0001);
        check("simul_no_ovr",       {15'h0, oOVR}, 16'h0000);
        found = 0;
        for (int i = 0; i < BOUND && found == 0; i++) begin
            if (oROW === 4'b1011) found = 1;
            else @(negedge clk);
        end
        check("reset_row_reached", found[15:0], 16'h0001);
        reset_n = 1'b0;
        #1;
        check("areset_row",   {12'h0, oROW}, 16'h000E);
        check("areset_keys",  oKEYS, 16'h0000);
        check("areset_key",   {12'h0, oKEY}, 16'h0000);
        check("areset_valid", {15'h0, oVALID}, 16'h0000);
        check("areset_ovr",   {15'h0, oOVR}, 16'h0000);
        key_down = '0;
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Ack collision: key 10's event lands on the same edge as the ack of key 5
        exp_q.push_back(4'd5);
        key_down[5] = 1'b1;
        wait_valid("coll_key5_valid", n);
        exp_q.push_back(4'd10);
        key_down[10] = 1'b1;
        wait_keys("coll_keys", 16'h0420);
        iACK = 1'b1;
        @(negedge clk) iACK = 1'b0;
        check("coll_key",   {12'h0, oKEY}, 16'h000A);
        check("coll_valid", {15'h0, oVALID}, 16'h0001);
        check("coll_ovr",   {15'h0, oOVR}, 16'h0000);
        ack();
        check("coll_ack_valid", {15'h0, oVALID}, 16'h0000);
        key_down = '0;
        wait_keys("coll_release", 16'h0000);

`ifdef KEYPAD_DIGITS_EN
        // Digit history
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        check("digits_cleared", oDIGITS, 16'h0000);
        for (int k = 1; k <= 4; k++) press_ack(k);
        check("digits_1234", oDIGITS, 16'h1234);
        press_ack(5);
        check("digits_2345", oDIGITS, 16'h2345);
`endif

        tick(FRAME);
        check("queue_drained", exp_q.size(), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
